rr_mux_reg: RTL and testbench
=============================

RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per data channel (>=1).
REQ-002 SHALL have parameter N_INS, default 64: channel count, a power of two in 2..64.
REQ-003 SHALL derive SEL_W = log2(N_INS), default 6.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port ins  input  [N_INS-1:0][WIDTH-1:0]: channel data.
REQ-007 SHALL have port ins_valid  input  N_INS: per-channel request.
REQ-008 SHALL have port ins_ready  output  N_INS: per-channel accept, at most one bit high per cycle.
REQ-009 SHALL have port fixed_en  input  1: 1 selects fixed mode, 0 selects round-robin mode.
REQ-010 SHALL have port fixed_sel  input  SEL_W: channel used in fixed mode.
REQ-011 SHALL have port out  output  WIDTH: registered selected data.
REQ-012 SHALL have port out_sel  output  SEL_W: registered index of the channel held in out.
REQ-013 SHALL have port out_valid  output  1: out holds an entry.
REQ-014 SHALL have port out_ready  input  1: downstream accepts.

Function
REQ-015 SHALL hold a single output register {out, out_sel, out_valid} and a round-robin pointer ptr (SEL_W bits).
REQ-016 SHALL define load_en = !out_valid | out_ready (empty, or draining this cycle).
REQ-017 SHALL, in fixed mode, set grant = fixed_sel when ins_valid[fixed_sel] is 1; otherwise there is no grant.
REQ-018 SHALL, in round-robin mode, grant the first i with ins_valid[i] = 1 scanning ptr, ptr+1, ... modulo N_INS (wrap from N_INS-1 to 0).
REQ-019 SHALL drive ins_ready[grant] = load_en combinationally; all other ins_ready bits SHALL be 0, and all SHALL be 0 when there is no grant.
REQ-020 SHALL, on input handshake (ins_valid[g] & ins_ready[g]), load out <= ins[g], out_sel <= g, and out_valid <= 1 at the next edge; latency is 1 cycle.
REQ-021 SHALL clear out_valid when out_valid & out_ready and no input handshake occurs in the same cycle; out and out_sel then hold their last values.
REQ-022 SHALL, on simultaneous drain and load, replace the entry with out_valid staying 1, sustaining one transfer per cycle.
REQ-023 SHALL hold out, out_sel and out_valid stable while out_valid & !out_ready.
REQ-024 SHALL update ptr <= g+1 (mod N_INS) only on a round-robin-mode input handshake; a fixed-mode handshake or an idle cycle SHALL leave ptr unchanged.
REQ-025 SHALL take effect immediately when fixed_en or fixed_sel changes, for the next grant only; an entry already registered is unaffected.
REQ-026 SHALL have no combinational path from ins or ins_valid to out or out_valid.
REQ-027 SHALL allow a combinational path from out_ready to ins_ready.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, set out_valid = 0, out = 0, out_sel = 0, ptr = 0.
REQ-029 SHALL drive all ins_ready bits to 0 while rst = 1.
REQ-030 SHALL, when reset is asserted mid-transfer, discard the held entry, and the channel whose handshake coincides with the reset cycle SHALL NOT be captured.

Verification
REQ-031 SHALL cover fixed mode: N_INS=64, WIDTH=8, fixed_en=1, fixed_sel=37, ins[37]=0xA5, all valid, out_ready=1 -> next cycle out=0xA5, out_sel=37, out_valid=1, ptr stays 0.
REQ-032 SHALL cover round-robin fairness: N_INS=4, all ins_valid=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover wrap-around: ptr=3, ins_valid=4'b0101 -> grant 0, then ptr=1, so the next grant is 2.
REQ-034 SHALL cover backpressure: out_valid=1, out_ready=0 for 5 cycles with ins_valid all 1 -> ins_ready=0 and out unchanged throughout; on out_ready=1, drain and load occur in the same cycle.
REQ-035 SHALL cover the empty case: ins_valid=0 and the register draining -> out_valid falls to 0 and out keeps its last value.
REQ-036 SHALL cover reset mid-operation: rst=1 while out_valid=1 and ptr=2 -> next cycle out_valid=0, out=0, out_sel=0, ptr=0, and no ins_ready is asserted during reset.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-to-1 request multiplexer with fixed/round-robin arbitration and a registered output stage
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ins        per-channel data, N_INS x WIDTH
//   ins_valid  per-channel request
//   ins_ready  per-channel accept (one-hot or zero)
//   fixed_en   1 = always serve fixed_sel, 0 = round-robin
//   fixed_sel  channel served in fixed mode
//   out        registered data of the selected channel
//   out_sel    registered index of the channel held in out
//   out_valid  out holds an entry
//   out_ready  downstream accepts the entry in out
module rr_mux_reg #(
    parameter int WIDTH = 1,
    parameter int N_INS = 64,
    localparam int SEL_W = $clog2(N_INS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_INS-1:0][WIDTH-1:0]  ins,
    input  logic [N_INS-1:0]             ins_valid,
    output logic [N_INS-1:0]             ins_ready,
    input  logic                         fixed_en,
    input  logic [SEL_W-1:0]             fixed_sel,
    output logic [WIDTH-1:0]             out,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [WIDTH-1:0] r_out;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant;
    logic             w_handshake;

    // The register can take a new entry when it is empty or being drained now.
    assign w_load_en = !r_out_valid || out_ready;

    // Grant selection. Round-robin scans from the highest offset down so the
    // requester closest to r_ptr (lowest offset) is the last one written and
    // therefore wins. N_INS is a power of two, so SEL_W-bit addition wraps.
    always_comb begin
        logic [SEL_W-1:0] idx;
        w_grant_valid = 1'b0;
        w_grant       = '0;
        idx           = '0;
        if (fixed_en) begin
            if (ins_valid[fixed_sel]) begin
                w_grant_valid = 1'b1;
                w_grant       = fixed_sel;
            end
        end else begin
            for (int k = N_INS - 1; k >= 0; k--) begin
                idx = r_ptr + SEL_W'(k);
                if (ins_valid[idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = idx;
                end
            end
        end
    end

    // Reset masks the accept so no channel believes it was captured during rst.
    assign w_handshake = w_grant_valid && w_load_en && !rst;

    always_comb begin
        ins_ready = '0;
        if (w_handshake) begin
            ins_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_handshake) begin
                r_out       <= ins[w_grant];
                r_out_sel   <= w_grant;
                r_out_valid <= 1'b1;
                // Fixed-mode transfers must not disturb round-robin fairness.
                if (!fixed_en) begin
                    r_ptr <= w_grant + SEL_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - scoreboard bench for rr_mux_reg (64-channel and 4-channel instances)
module tb_rr_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [63:0][7:0] a_ins;
    logic [63:0]      a_valid, a_ready;
    logic             a_fen;
    logic [5:0]       a_fsel;
    logic [7:0]       a_out;
    logic [5:0]       a_osel;
    logic             a_ovalid, a_oready;

    logic [3:0][7:0]  b_ins;
    logic [3:0]       b_valid, b_ready;
    logic             b_fen;
    logic [1:0]       b_fsel;
    logic [7:0]       b_out;
    logic [1:0]       b_osel;
    logic             b_ovalid, b_oready;

    rr_mux_reg #(.WIDTH(8), .N_INS(64)) dut_a (
        .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_valid), .ins_ready(a_ready),
        .fixed_en(a_fen), .fixed_sel(a_fsel), .out(a_out), .out_sel(a_osel),
        .out_valid(a_ovalid), .out_ready(a_oready)
    );

    rr_mux_reg #(.WIDTH(8), .N_INS(4)) dut_b (
        .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_valid), .ins_ready(b_ready),
        .fixed_en(b_fen), .fixed_sel(b_fsel), .out(b_out), .out_sel(b_osel),
        .out_valid(b_ovalid), .out_ready(b_oready)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] s;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output transfer is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_ovalid && a_oready) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got sel %0d data %0h expected no transfer", a_osel, a_out);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_out", 64'(a_out), 64'(e.d));
                    chk("a_out_sel", 64'(a_osel), 64'(e.s));
                end
            end
            if (b_ovalid && b_oready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got sel %0d data %0h expected no transfer", b_osel, b_out);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_out", 64'(b_out), 64'(e.d));
                    chk("b_out_sel", 64'(b_osel), 64'(e.s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_fen = 1'b1; a_fsel = 6'd37; a_oready = 1'b1; a_valid = '1;
        b_fen = 1'b0; b_fsel = 2'd0;  b_oready = 1'b1; b_valid = '1;
        for (int i = 0; i < 64; i++) a_ins[i] = 8'(i + 1);
        a_ins[37] = 8'hA5;
        for (int i = 0; i < 4; i++) b_ins[i] = 8'(8'h10 + i);

        // Reset with every channel requesting.
        next();
        @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'h0);
        chk("rst_b_ready", 64'(b_ready), 64'h0);
        chk("rst_a_valid", 64'(a_ovalid), 64'h0);
        chk("rst_a_out", 64'(a_out), 64'h0);
        chk("rst_a_sel", 64'(a_osel), 64'h0);
        chk("rst_b_valid", 64'(b_ovalid), 64'h0);
        next();
        rst = 1'b0;
        b_valid = '0;

        // Fixed mode on channel 37.
        exp_a.push_back(exp_t'{d: 8'hA5, s: 6'd37});
        @(negedge clk);
        chk("fixed_ready", 64'(a_ready), 64'h1 << 37);
        next();
        a_valid = '0;
        @(negedge clk);
        chk("fixed_out_valid", 64'(a_ovalid), 64'h1);
        next();

        // Fixed channel idle -> no grant even though others request.
        a_valid = '1;
        a_valid[37] = 1'b0;
        @(negedge clk);
        chk("fixed_idle_ready", 64'(a_ready), 64'h0);
        next();

        // Round-robin: pointer untouched by the fixed transfer, so channel 0 first.
        a_fen = 1'b0;
        a_valid = '1;
        exp_a.push_back(exp_t'{d: 8'd1, s: 6'd0});
        @(negedge clk);
        chk("rr_first_ready", 64'(a_ready), 64'h1);
        next();
        exp_a.push_back(exp_t'{d: 8'd2, s: 6'd1});
        next();
        // Mode switch takes effect immediately; fixed transfer keeps ptr at 2.
        a_fen = 1'b1; a_fsel = 6'd5;
        exp_a.push_back(exp_t'{d: 8'd6, s: 6'd5});
        next();
        a_fen = 1'b0;
        exp_a.push_back(exp_t'{d: 8'd3, s: 6'd2});
        next();
        a_valid = '0;
        repeat (2) next();

        // 4-channel fairness: 0,1,2,3,0.
        b_valid = '1;
        for (int k = 0; k < 5; k++) begin
            exp_b.push_back(exp_t'{d: 8'(8'h10 + (k % 4)), s: 6'(k % 4)});
            next();
        end
        b_valid = '0;
        next();
        // Drained with nothing pending.
        @(negedge clk);
        chk("empty_valid", 64'(b_ovalid), 64'h0);
        chk("empty_hold_out", 64'(b_out), 64'h10);
        chk("empty_hold_sel", 64'(b_osel), 64'h0);
        next();

        // Move ptr to 3, then wrap: 0101 -> grant 0, then grant 2.
        b_valid = 4'b0100;
        exp_b.push_back(exp_t'{d: 8'h12, s: 6'd2});
        next();
        b_valid = 4'b0101;
        exp_b.push_back(exp_t'{d: 8'h10, s: 6'd0});
        @(negedge clk);
        chk("wrap_grant0", 64'(b_ready), 64'h1);
        next();
        exp_b.push_back(exp_t'{d: 8'h12, s: 6'd2});
        @(negedge clk);
        chk("wrap_grant2", 64'(b_ready), 64'h4);
        next();
        b_valid = '0;
        next();

        // Backpressure: ptr=3 so channel 3 loads, then held for 5 cycles.
        b_oready = 1'b0;
        b_valid = '1;
        exp_b.push_back(exp_t'{d: 8'h13, s: 6'd3});
        next();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 64'(b_ready), 64'h0);
            chk("bp_out", 64'(b_out), 64'h13);
            chk("bp_valid", 64'(b_ovalid), 64'h1);
            next();
        end
        b_oready = 1'b1;
        exp_b.push_back(exp_t'{d: 8'h10, s: 6'd0});
        @(negedge clk);
        chk("drain_load_ready", 64'(b_ready), 64'h1);
        next();
        b_valid = '0;
        @(negedge clk);
        chk("drain_load_valid", 64'(b_ovalid), 64'h1);
        chk("drain_load_out", 64'(b_out), 64'h10);
        next();

        // Reset mid-operation: hold channel 1 with ptr=2, then reset.
        b_oready = 1'b0;
        b_valid = 4'b0010;
        next();
        b_valid = '1;
        b_oready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(b_ready), 64'h0);
        next();
        rst = 1'b0;
        b_valid = '0;
        @(negedge clk);
        chk("midrst_valid", 64'(b_ovalid), 64'h0);
        chk("midrst_out", 64'(b_out), 64'h0);
        chk("midrst_sel", 64'(b_osel), 64'h0);
        next();
        // ptr back to 0.
        b_valid = '1;
        exp_b.push_back(exp_t'{d: 8'h10, s: 6'd0});
        @(negedge clk);
        chk("midrst_ptr_ready", 64'(b_ready), 64'h1);
        next();
        b_valid = '0;
        repeat (3) next();

        chk("a_scoreboard_empty", 64'(exp_a.size()), 64'h0);
        chk("b_scoreboard_empty", 64'(exp_b.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
